fetch_pc_ctrl: RTL
==================

# fetch_pc_ctrl

Instruction-fetch (IF) stage controller. It sits directly upstream of the ID-stage branch predictor and consumes that predictor's `pred_takeD`/`branch_targetD`. It also takes EX mispredict and exception redirects, drives the instruction SRAM-like bus (one outstanding request), and buffers one fetched instruction for ID. Redirect priority is exception > EX mispredict > ID prediction > sequential. MIPS delay slots are honoured.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `stallF  in  1`: ID not accepting; holds the buffered instruction.
- `pred_takeD  in  1`: ID predicts taken. Already gated by ID enable.
- `branch_targetD  in  32`: predicted target.
- `mispredE  in  1`: EX resolved a misprediction.
- `redirect_pcE  in  32`: correct PC from EX.
- `excM  in  1`: exception or eret flush.
- `exc_pcM  in  32`: handler or EPC address.
- `inst_req  out  1`: request valid.
- `inst_addr  out  32`: request address.
- `inst_addr_ok  in  1`: address accepted.
- `inst_data_ok  in  1`: data returned.
- `inst_rdata  in  32`: returned data.
- `validF  out  1`: instF/pcF hold an instruction for ID.
- `instF  out  32`: buffered instruction.
- `pcF  out  32`: PC of instF.
- `adelF  out  1`: fetch address error for pcF.

## Operation
Registers:
- `pc_reg`: next address to issue.
- `state`: one of S_REQ, S_WAIT, S_FULL.
- `drop`: discard the next data_ok.
- `pend_valid` / `pend_target`: taken prediction waiting for the delay slot to issue.
- Buffers: `instF`, `pcF`, `adelF`, plus `req_pc` (address of the outstanding request).

State machine:
- **S_REQ**
  - `inst_req=1`, `inst_addr=pc_reg`.
  - If `pc_reg[1:0]!=0`: no request is issued. Go to S_FULL with `instF=0`, `pcF=pc_reg`, `adelF=1`.
  - On `inst_addr_ok`: `req_pc<=pc_reg`. Set `pc_reg <= pend_valid ? pend_target : pc_reg+4`, clear `pend_valid`, go to S_WAIT.
- **S_WAIT**
  - `inst_req=0`.
  - On `inst_data_ok` with `drop=0`: capture `inst_rdata`/`req_pc` into the buffer (`adelF=0`) and go to S_FULL.
  - On `inst_data_ok` with `drop=1`: clear `drop`, go to S_REQ.
- **S_FULL**
  - `validF=1`.
  - When `stallF=0`: the instruction is consumed; go to S_REQ next cycle.

Redirects (`excM` or `mispredE`):
- `pc_reg` loads the winning address (`exc_pcM` over `redirect_pcE`). `pend_valid` is cleared.
- S_REQ without `addr_ok`: the address changes next cycle; nothing is dropped.
- S_REQ with `addr_ok` in the same cycle, or S_WAIT without `data_ok`: go to or stay in S_WAIT with `drop=1`.
- S_WAIT with `data_ok` in the same cycle: discard the data, go to S_REQ.
- S_FULL: the buffer is invalidated and the FSM goes to S_REQ.
- The redirect overrides any `pred_takeD` in the same cycle.

Prediction (`pred_takeD` with no redirect in the same cycle):
- If the delay slot is not yet accepted (state S_REQ and `addr_ok=0`): `pend_valid<=1`, `pend_target<=branch_targetD`.
- Otherwise (delay slot accepted this cycle or earlier): `pc_reg<=branch_targetD` directly.
- This rule takes precedence over the +4 update.

Other rules:
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- The interface holds at most one outstanding request.
- Address stability: once `inst_req` is high, `inst_addr` changes only because of a redirect. The bus tolerates this while `addr_ok` is low.

## Timing
- In the reset cycle and after it: `state=S_REQ`, `pc_reg=RESET_PC`, `drop=0`, `pend_valid=0`, `validF=0`, `instF=0`, `pcF=0`, `adelF=0`, `inst_req=0`.
  - `inst_req` is forced low while `rst` is high.
  - `inst_req=1` in the first cycle after reset deasserts.
- Reset asserted mid-request abandons any in-flight response. The bus is reset together with this block.
- Latency with same-cycle `addr_ok` and next-cycle `data_ok`: request at cycle t, data at t+1, `validF` at t+2, next request at t+3 if no stall.
- The buffer holds its contents while `stallF=1`; `instF`/`pcF` are stable.
- Redirect to new request: `inst_addr` shows the redirect PC in the cycle after the redirect in S_REQ or S_FULL. From S_WAIT it appears after the dropped `data_ok` is absorbed.

## Structure
- Shared package `cpu_defs_pkg`: the `fetch_state_t` enum (S_REQ, S_WAIT, S_FULL) and the `RESET_PC` constant.
- One natural sub-module, `fetch_buf`: a single-entry instruction/PC/adel register with load, hold and invalidate controls.

## Test plan
- **Reset then sequential fetch:** `addr_ok`/`data_ok` always 1 → addresses BFC0_0000, BFC0_0004, BFC0_0008. `pcF` follows one request behind.
- **Prediction before delay slot issues:** `pred_takeD=1` with target BFC0_0100 while S_REQ holds BFC0_0008 with `addr_ok=0`. Then `addr_ok=1` → issue BFC0_0008, then BFC0_0100.
- **Prediction after delay slot accepted:** same, but in S_WAIT with delay slot 0008 → next address BFC0_0100, never BFC0_000C.
- **Mispredict in S_WAIT:** `redirect_pcE`=BFC0_0200, `data_ok` two cycles later with 0x1234_5678 → `validF` stays 0, next request BFC0_0200.
- **Simultaneous events:** `excM` (8000_0180) with `mispredE` and `pred_takeD` in S_FULL → buffer invalidated, next `inst_addr`=8000_0180, `pend_valid=0`.
- **Misaligned redirect and stall:** `redirect_pcE`=BFC0_0002 → no `inst_req`, `validF=1`, `adelF=1`, `pcF`=BFC0_0002. Held for 3 `stallF` cycles, released on the 4th.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, reset vector and
// an alignment helper used by the IF stage.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry IF/ID holding register for one fetched instruction, its PC
// and its address-error flag.
module fetch_buf
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inval,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    input  logic        adel_in,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        adel
);

    logic        valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_reg;
    logic        adel_reg;

    // Contents survive an invalidate; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            inst_reg  <= 32'd0;
            pc_reg    <= 32'd0;
            adel_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            inst_reg  <= inst_in;
            pc_reg    <= pc_in;
            adel_reg  <= adel_in;
        end else if (inval) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign inst  = inst_reg;
    assign pc    = pc_reg;
    assign adel  = adel_reg;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage controller: PC selection (exception > mispredict > prediction >
// sequential), one-outstanding instruction bus handshake and IF/ID buffer.
module fetch_pc_ctrl
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        pred_takeD,
    input  logic [31:0] branch_targetD,
    input  logic        mispredE,
    input  logic [31:0] redirect_pcE,
    input  logic        excM,
    input  logic [31:0] exc_pcM,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        validF,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic        adelF
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  req_pc_reg;
    logic         drop_reg;
    logic         pend_valid_reg;
    logic [31:0]  pend_target_reg;

    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         pc_aligned;
    logic         accept;
    logic         buf_load;
    logic         buf_inval;
    logic [31:0]  buf_inst_in;
    logic [31:0]  buf_pc_in;
    logic         buf_adel_in;

    assign redirect    = excM | mispredE;
    assign redirect_pc = excM ? exc_pcM : redirect_pcE;
    assign pc_aligned  = is_word_aligned(pc_reg);
    assign accept      = (state_reg == S_REQ) && pc_aligned && inst_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_REQ;
            pc_reg          <= RESET_PC;
            req_pc_reg      <= 32'd0;
            drop_reg        <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= 32'd0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (accept) begin
                        req_pc_reg     <= pc_reg;
                        pc_reg         <= pend_valid_reg ? pend_target_reg : pc_reg + 32'd4;
                        pend_valid_reg <= 1'b0;
                        state_reg      <= S_WAIT;
                        if (redirect)
                            drop_reg <= 1'b1;
                    end else if (!pc_aligned && !redirect) begin
                        state_reg <= S_FULL;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        drop_reg  <= 1'b0;
                        state_reg <= (drop_reg || redirect) ? S_REQ : S_FULL;
                    end else if (redirect) begin
                        drop_reg <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (!stallF || redirect)
                        state_reg <= S_REQ;
                end
                default: state_reg <= S_REQ;
            endcase

            // Later assignments override the sequential PC update above.
            if (redirect) begin
                pc_reg         <= redirect_pc;
                pend_valid_reg <= 1'b0;
            end else if (pred_takeD) begin
                if (state_reg == S_REQ && !accept) begin
                    pend_valid_reg  <= 1'b1;
                    pend_target_reg <= branch_targetD;
                end else begin
                    pc_reg <= branch_targetD;
                end
            end
        end
    end

    always_comb begin
        buf_load    = 1'b0;
        buf_inst_in = inst_rdata;
        buf_pc_in   = req_pc_reg;
        buf_adel_in = 1'b0;
        if (!redirect) begin
            if (state_reg == S_WAIT && inst_data_ok && !drop_reg) begin
                buf_load = 1'b1;
            end else if (state_reg == S_REQ && !pc_aligned) begin
                // Misaligned PC: deliver a bubble flagged with the address error.
                buf_load    = 1'b1;
                buf_inst_in = 32'd0;
                buf_pc_in   = pc_reg;
                buf_adel_in = 1'b1;
            end
        end
    end

    assign buf_inval = (state_reg == S_FULL) && (!stallF || redirect);

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .inval   (buf_inval),
        .inst_in (buf_inst_in),
        .pc_in   (buf_pc_in),
        .adel_in (buf_adel_in),
        .valid   (validF),
        .inst    (instF),
        .pc      (pcF),
        .adel    (adelF)
    );

    assign inst_req  = !rst && (state_reg == S_REQ) && pc_aligned;
    assign inst_addr = pc_reg;

endmodule
